// File: rtl/tdc_stim_pkg.sv
// Shared constants for the TDC stimulus generator: default field widths and FSM state encodings.
// The optional delay sweep is controlled by the TDC_STIM_SWEEP_EN macro (see tdc_stim_gen).
package tdc_stim_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int PULSE_W_DEF = 2;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t GAP  = 2'd2;
    localparam state_t FIN  = 2'd3;

endpackage

// File: rtl/tdc_stim_gen_pulse_timer.sv
// One-shot pulse timer: after a fire strobe, output goes high 'delay' cycles later for PULSE_W cycles.
// 'last' flags the final cycle of the pulse so the caller can chain the next event on that edge.
module tdc_pulse_timer
    import tdc_stim_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             fire,
    input  logic [CNT_W-1:0] delay,
    output logic             pulse,
    output logic             last
);

    logic             active;
    logic [CNT_W-1:0] dly;
    logic [CNT_W:0]   elapsed;
    logic [CNT_W:0]   elapsed_nxt;
    logic [CNT_W:0]   end_cnt;

    // One extra bit so delay + PULSE_W never wraps.
    assign end_cnt     = {1'b0, dly} + (CNT_W+1)'(PULSE_W);
    assign elapsed_nxt = elapsed + (CNT_W+1)'(1);
    assign last        = active && (elapsed_nxt == end_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            dly     <= '0;
            elapsed <= '0;
            pulse   <= 1'b0;
        end else if (clear) begin
            active  <= 1'b0;
            elapsed <= '0;
            pulse   <= 1'b0;
        end else if (fire) begin
            active  <= 1'b1;
            dly     <= delay;
            elapsed <= '0;
            pulse   <= (delay == '0);
        end else if (active) begin
            elapsed <= elapsed_nxt;
            pulse   <= (elapsed_nxt >= {1'b0, dly}) && (elapsed_nxt < end_cnt);
            if (elapsed_nxt == end_cnt) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tdc_stim_gen.sv
// Start/stop pulse-pair generator feeding the TDC for self-test and calibration.
// Define TDC_STIM_SWEEP_EN to step the stop delay by one cycle per pair (wrapping modulo 2^CNT_W).
module tdc_stim_gen
    import tdc_stim_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_gap,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start_req,
    output logic             start_o,
    output logic             stop_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_idx
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] dly_sh;
    logic [CNT_W-1:0] gap_sh;
    logic [CNT_W-1:0] cnt_sh;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] pair_inc;
    logic [CNT_W-1:0] fire_dly;
    logic             fire;
    logic             stop_last;
    logic             start_last_unused;

    assign pair_inc = pair_idx + ONE;
    assign busy     = (state == RUN) || (state == GAP);
    assign done     = (state == FIN);

    // A new pair is launched on accept, on a zero-gap back-to-back pair, or at the end of a gap.
    always_comb begin
        fire = 1'b0;
        case (state)
            IDLE:    fire = start_req && (cfg_count != '0);
            RUN:     fire = stop_last && (pair_inc != cnt_sh) && (gap_sh == '0);
            GAP:     fire = (gap_cnt == gap_sh - ONE);
            default: fire = 1'b0;
        endcase
        if (!ena) begin
            fire = 1'b0;
        end
    end

`ifdef TDC_STIM_SWEEP_EN
    logic [CNT_W-1:0] sweep_k;
    assign sweep_k  = (state == RUN) ? pair_inc : pair_idx;
    assign fire_dly = (state == IDLE) ? cfg_delay : dly_sh + sweep_k;
`else
    assign fire_dly = (state == IDLE) ? cfg_delay : dly_sh;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dly_sh   <= '0;
            gap_sh   <= '0;
            cnt_sh   <= '0;
            gap_cnt  <= '0;
            pair_idx <= '0;
        end else if (!ena) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        dly_sh   <= cfg_delay;
                        gap_sh   <= cfg_gap;
                        cnt_sh   <= cfg_count;
                        pair_idx <= '0;
                        state    <= (cfg_count == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    // The stop pulse never ends before the start pulse, so its last cycle closes the pair.
                    if (stop_last) begin
                        pair_idx <= pair_inc;
                        if (pair_inc == cnt_sh) begin
                            state <= FIN;
                        end else if (gap_sh != '0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == gap_sh - ONE) begin
                        state <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tdc_pulse_timer #(
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) u_start_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!ena),
        .fire  (fire),
        .delay ('0),
        .pulse (start_o),
        .last  (start_last_unused)
    );

    tdc_pulse_timer #(
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) u_stop_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!ena),
        .fire  (fire),
        .delay (fire_dly),
        .pulse (stop_o),
        .last  (stop_last)
    );

endmodule

// File: tb/tb_tdc_stim_gen.sv
// Bench for tdc_stim_gen: a reference trace of expected per-cycle outputs is queued at stimulus time
// and compared entry by entry as the design runs. Honours TDC_STIM_SWEEP_EN in its reference model.
module tb_tdc_stim_gen;

    localparam int CNT_W   = 8;
    localparam int PULSE_W = 2;
    localparam int EW      = CNT_W + 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             start_req = 1'b0;
    logic [CNT_W-1:0] cfg_delay = '0;
    logic [CNT_W-1:0] cfg_gap = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic             start_o;
    logic             stop_o;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pair_idx;

    logic [EW-1:0] obs;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    int            trace_idx = 0;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    tdc_stim_gen #(
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cfg_delay (cfg_delay),
        .cfg_gap   (cfg_gap),
        .cfg_count (cfg_count),
        .start_req (start_req),
        .start_o   (start_o),
        .stop_o    (stop_o),
        .busy      (busy),
        .done      (done),
        .pair_idx  (pair_idx)
    );

    assign obs = {start_o, stop_o, busy, done, pair_idx};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [EW-1:0] pack(input bit s, input bit p, input bit b, input bit dn, input int pr);
        logic [31:0] prv;
        prv = pr;
        return {s, p, b, dn, prv[CNT_W-1:0]};
    endfunction

    // Independent reference: expected output vector for each cycle after the accepting edge.
    task automatic buildTrace(input int d, input int g, input int n, input int abort_at,
                              input int tail, output int len);
        logic [EW-1:0] tr[$];
        logic [EW-1:0] last_e;
        int            dk;
        int            fin_pair;
        if (n == 0) begin
            tr.push_back(pack(0, 0, 0, 1, 0));
        end else begin
            for (int k = 0; k < n; k++) begin
`ifdef TDC_STIM_SWEEP_EN
                dk = (d + k) % (1 << CNT_W);
`else
                dk = d;
`endif
                for (int c = 0; c < dk + PULSE_W; c++)
                    tr.push_back(pack(c < PULSE_W, (c >= dk) && (c < dk + PULSE_W), 1, 0, k));
                if (k < n - 1)
                    for (int c = 0; c < g; c++) tr.push_back(pack(0, 0, 1, 0, k + 1));
            end
            tr.push_back(pack(0, 0, 0, 1, n));
        end
        fin_pair = n;
        if (abort_at > 0 && abort_at < tr.size()) begin
            last_e = tr[abort_at-1];
            fin_pair = int'(last_e[CNT_W-1:0]);
            while (tr.size() > abort_at) void'(tr.pop_back());
        end
        for (int i = 0; i < tail; i++) tr.push_back(pack(0, 0, 0, 0, fin_pair));
        len = tr.size();
        foreach (tr[i]) exp_q.push_back(tr[i]);
    endtask

    // Returns at the negedge after the accepting edge with start_req released unless held.
    task automatic applyStimulus(input int d, input int g, input int n, input int abort_at,
                                 input int tail, input bit hold);
        int len;
        @(negedge clk);
        cfg_delay = CNT_W'(d);
        cfg_gap   = CNT_W'(g);
        cfg_count = CNT_W'(n);
        start_req = 1'b1;
        buildTrace(d, g, n, abort_at, tail, len);
        @(negedge clk);
        if (!hold) start_req = 1'b0;
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput($sformatf("trace[%0d]", trace_idx), 32'(obs), 32'(mon_e));
            trace_idx++;
        end
    end

    initial begin
        int l1;
        int l2;
        #2;
        checkOutput("reset_state", 32'(obs), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;

        applyStimulus(5, 3, 1, -1, 3, 1'b0);
        waitDrain();
        applyStimulus(0, 0, 2, -1, 3, 1'b0);
        waitDrain();
        applyStimulus(1, 2, 3, -1, 3, 1'b0);
        waitDrain();
        applyStimulus(9, 9, 0, -1, 3, 1'b0);
        waitDrain();

        // Request during a run must be dropped, not queued.
        applyStimulus(3, 1, 1, -1, 5, 1'b0);
        @(negedge clk);
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        waitDrain();

        // ena dropped mid-delay of pair 1 of 4, then a fresh sequence.
        applyStimulus(6, 2, 4, 13, 3, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        waitDrain();
        @(negedge clk);
        ena = 1'b1;
        applyStimulus(2, 1, 2, -1, 3, 1'b0);
        waitDrain();

        // start_req held high: back-to-back sequences, mid-run cfg edits only affect the next accept.
        @(negedge clk);
        cfg_delay = 8'd4;
        cfg_gap   = 8'd2;
        cfg_count = 8'd2;
        start_req = 1'b1;
        buildTrace(4, 2, 2, -1, 1, l1);
        buildTrace(7, 0, 2, -1, 3, l2);
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cfg_delay = 8'd7;
        cfg_gap   = 8'd0;
        cfg_count = 8'd2;
        repeat (l1 - 2) @(posedge clk);
        @(negedge clk);
        start_req = 1'b0;
        cfg_delay = 8'd1;
        cfg_gap   = 8'd5;
        cfg_count = 8'd9;
        waitDrain();

        applyStimulus(254, 1, 3, -1, 3, 1'b0);
        waitDrain();
        applyStimulus(255, 0, 1, -1, 3, 1'b0);
        waitDrain();

        // Asynchronous reset while start_o is high.
        @(negedge clk);
        cfg_delay = 8'd20;
        cfg_gap   = 8'd0;
        cfg_count = 8'd1;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        checkOutput("pre_rst_busy", 32'({start_o, busy}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 32'(obs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_idle", 32'(obs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
